// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and helpers for the iterative shift-and-add multiplier.
// State encodings are fixed so that they stay visible on the ALU debug bus.
package shift_add_multiplier_pkg;

    localparam logic [1:0] MUL_IDLE = 2'b00;
    localparam logic [1:0] MUL_RUN  = 2'b01;
    localparam logic [1:0] MUL_DONE = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One-bit full-add cell; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/Busy/Done handshake and operand/result bus between the ALU decode and the multiplier.
// The master side is the ALU decode; the slave side is the multiplier.
interface shift_add_multiplier_if #(parameter int N = 32);

    logic           Start;
    logic [N-1:0]   Multiplicand;
    logic [N-1:0]   Multiplier;
    logic           Busy;
    logic           Done;
    logic [2*N-1:0] Product;

    modport master (
        output Start, Multiplicand, Multiplier,
        input  Busy, Done, Product
    );

    modport slave (
        input  Start, Multiplicand, Multiplier,
        output Busy, Done, Product
    );

endinterface

// File: rtl/shift_add_multiplier_add_stage.sv
// N-bit ripple adder built from full-add cells; En gates the B operand to zero.
// This is the multiplier's only adder, shared by every step of an operation.
module shift_add_multiplier_add_stage
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         En,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic       carry;
    logic [1:0] fa;

    always_comb begin
        carry = 1'b0;
        fa    = 2'b00;
        Sum   = '0;
        for (int i = 0; i < N; i++) begin
            fa     = full_add(A[i], B[i] & En, carry);
            Sum[i] = fa[0];
            carry  = fa[1];
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned N x N -> 2N multiplier: one multiplier bit per cycle, N+1 cycles per result.
// Start is honoured only in IDLE or DONE; Product is registered and only updates on entry to DONE.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    shift_add_multiplier_if.slave bus
);

    localparam int CNT_W = clog2(N);

    logic [1:0]       state_q, state_d;
    logic [N:0]       acc_hi_q, acc_hi_d;
    logic [N-1:0]     acc_lo_q, acc_lo_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             top_bit;
    logic             accept;
    logic             last_step;

    shift_add_multiplier_add_stage #(.N(N)) u_add_stage (
        .A    (acc_hi_q[N-1:0]),
        .B    (mcand_q),
        .En   (acc_lo_q[0]),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    assign accept    = ((state_q == MUL_IDLE) || (state_q == MUL_DONE)) && bus.Start;
    assign last_step = (state_q == MUL_RUN) && (cnt_q == CNT_W'(N - 1));
    // Acc_hi[N] and the adder carry are never both set, so OR gives the true sum MSB.
    assign top_bit   = add_cout | acc_hi_q[N];

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= MUL_IDLE;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = MUL_IDLE;
        case (state_q)
            MUL_IDLE: state_d = bus.Start ? MUL_RUN : MUL_IDLE;
            MUL_RUN:  state_d = last_step ? MUL_DONE : MUL_RUN;
            MUL_DONE: state_d = bus.Start ? MUL_RUN : MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_comb begin
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            acc_hi_d = '0;
            acc_lo_d = bus.Multiplier;
            mcand_d  = bus.Multiplicand;
            cnt_d    = '0;
        end else if (state_q == MUL_RUN) begin
            acc_hi_d = {1'b0, top_bit, add_sum[N-1:1]};
            acc_lo_d = {add_sum[0], acc_lo_q[N-1:1]};
            cnt_d    = last_step ? cnt_q : cnt_q + CNT_W'(1);
            if (last_step) begin
                product_d = {top_bit, add_sum, acc_lo_q[N-1:1]};
            end
        end
    end

    always_comb begin
        bus.Busy    = (state_q == MUL_RUN);
        bus.Done    = (state_q == MUL_DONE);
        bus.Product = product_q;
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed scoreboard bench for shift_add_multiplier at N=8.
// Stimulus pushes expected product and Done cycle; a negedge monitor pops and compares on Done.
module tb_shift_add_multiplier;

    localparam int N = 8;

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    logic done_prev;
    exp_t sb_q[$];

    shift_add_multiplier_if #(.N(N)) bus ();

    shift_add_multiplier #(.N(N)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.Done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got Done at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check("product", 64'(bus.Product), 64'(e.prod));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
            check("done_width", 64'(done_prev), 64'd0);
        end
        done_prev <= bus.Done;
    end

    // Caller is positioned at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
        exp_t e;
        bus.Start        = 1'b1;
        bus.Multiplicand = a;
        bus.Multiplier   = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.prod = 16'(a) * 16'(b);
            e.cyc  = cyc + N;
            sb_q.push_back(e);
        end
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.Busy) busy_cnt++;
            if (bus.Done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no Done within 40 cycles expected Done", name);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        int bc;
        @(negedge clk);
        issue(a, b, 1'b1);
        wait_done(name, bc);
    endtask

    initial begin
        int bc;
        checks           = 0;
        failures         = 0;
        done_prev        = 1'b0;
        rst_n            = 1'b0;
        bus.Start        = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_product", 64'(bus.Product), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic op with busy-length check
        issue(8'h0D, 8'h0B, 1'b1);
        wait_done("basic", bc);
        check("busy_cycles", 64'(bc), 64'(N));
        idle_cycles(2);

        // Carry path and single-bit operands
        run_op("ff_ff", 8'hFF, 8'hFF);
        run_op("80_02", 8'h80, 8'h02);
        idle_cycles(3);
        check("product_hold", 64'(bus.Product), 64'h0100);
        check("idle_done", 64'(bus.Done), 64'd0);

        // Zero operands still take the full latency
        run_op("zero_a", 8'h00, 8'hAB);
        run_op("zero_b", 8'hC3, 8'h00);
        run_op("one_ff", 8'h01, 8'hFF);

        // Start during RUN is ignored
        @(negedge clk);
        issue(8'd3, 8'd5, 1'b1);
        idle_cycles(2);
        @(negedge clk);
        issue(8'd7, 8'd7, 1'b0);
        check("busy_ignore", 64'(bus.Busy), 64'd1);
        wait_done("ignore", bc);
        idle_cycles(12);
        check("ignore_idle", 64'(bus.Busy), 64'd0);

        // Back-to-back: Start presented while Done is high
        run_op("b2b_first", 8'h05, 8'h06);
        issue(8'h12, 8'h34, 1'b1);
        wait_done("b2b_second", bc);
        idle_cycles(2);

        // Reset mid-RUN discards the operation
        @(negedge clk);
        issue(8'h33, 8'h44, 1'b0);
        idle_cycles(3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_product", 64'(bus.Product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(12);
        check("abort_idle_busy", 64'(bus.Busy), 64'd0);
        check("abort_idle_product", 64'(bus.Product), 64'd0);
        run_op("after_abort", 8'd2, 8'd9);
        idle_cycles(3);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
